// File: rtl/dphy_pkg.sv
// -----------------------------------------------------------------------------
// dphy_pkg
// Shared constants for the DSI band buffer and the packet engine's address
// generator: frame geometry, band size, write-FSM state codes and the 8x8-tile
// address function. Both sides must use dphy_tile_addr so that the order
// pixels are written in matches the order the engine reads them back.
// -----------------------------------------------------------------------------
package dphy_pkg;

   localparam int DPHY_COLS      = 240;
   localparam int DPHY_ROWS      = 240;
   localparam int DPHY_BAND_ROWS = 8;
   localparam int DPHY_BAND_SIZE = DPHY_COLS * DPHY_BAND_ROWS;   // 1920 entries
   localparam int DPHY_BANDS     = DPHY_ROWS / DPHY_BAND_ROWS;   // 30 bands/frame
   localparam int DPHY_DATA_W    = 16;
   localparam int DPHY_ADDR_W    = 12;

   // Write-side FSM state codes
   localparam logic [0:0] W_FILL = 1'b0;
   localparam logic [0:0] W_WAIT = 1'b1;

   // RGB565 pixel layout as delivered by the host
   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   // Tile address of a pixel inside a band: each 8x8 tile occupies 64
   // consecutive entries, row-major inside the tile, tiles left to right.
   //   addr = row_in_band*8 + (col/8)*64 + col%8
   function automatic logic [DPHY_ADDR_W-1:0] dphy_tile_addr(
      input logic [2:0] row_in_band,
      input logic [7:0] col
   );
      dphy_tile_addr = {6'd0, row_in_band, 3'b000}
                     + {1'b0, col[7:3], 6'b000000}
                     + {9'd0, col[2:0]};
   endfunction

endpackage

// File: rtl/dphy_band_ram.sv
// -----------------------------------------------------------------------------
// dphy_band_ram
// Dual-bank simple dual-port pixel store (2 x DEPTH x DATA_W), one write port
// and one read port, with a registered read so it maps onto block RAM.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset (clears only the read register)
//   wr_en    write strobe
//   wr_bank  bank being written
//   wr_addr  entry within the bank
//   wr_data  pixel to store
//   rd_bank  bank being read
//   rd_addr  entry within the bank; addresses >= DEPTH read as zero
//   rd_data  registered read data, valid one cycle after rd_addr
// -----------------------------------------------------------------------------
module dphy_band_ram
   import dphy_pkg::*;
#(
   parameter int DATA_W = DPHY_DATA_W,
   parameter int ADDR_W = DPHY_ADDR_W,
   parameter int DEPTH  = DPHY_BAND_SIZE
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              wr_bank,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_bank,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int IDX_W = $clog2(2 * DEPTH);

   // Bank 0 occupies [0, DEPTH), bank 1 occupies [DEPTH, 2*DEPTH)
   logic [DATA_W-1:0] mem [0:2*DEPTH-1];

   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_in_range;
   logic              wr_in_range;
   logic [DATA_W-1:0] rd_data_q;

   always_comb begin
      wr_idx      = IDX_W'(wr_addr) + (wr_bank ? IDX_W'(DEPTH) : '0);
      rd_idx      = IDX_W'(rd_addr) + (rd_bank ? IDX_W'(DEPTH) : '0);
      wr_in_range = (wr_addr < ADDR_W'(DEPTH));
      rd_in_range = (rd_addr < ADDR_W'(DEPTH));
   end

   // Contents are never cleared; only the bank flags in the controller say
   // whether they mean anything.
   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Read-before-write on a same-address collision: the old word is returned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_in_range) begin
         rd_data_q <= mem[rd_idx];
      end else begin
         rd_data_q <= '0;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/dphy_band_buffer.sv
// -----------------------------------------------------------------------------
// dphy_band_buffer
// Ping-pong band buffer between the host raster pixel stream and the DSI
// packet engine. Pixels arrive in raster order and are stored as 8-row bands
// in 8x8-tile order; one bank fills while the other is served to the engine.
//
// Ports:
//   sysclk    sole clock
//   reset     asynchronous active-high reset
//   wr_valid  host pixel valid
//   wr_ready  buffer can accept a pixel
//   wr_sof    first pixel of a frame (qualified by wr_valid)
//   wr_data   RGB565 pixel
//   rd_addr   tile address from the packet engine
//   rd_data   pixel at rd_addr in the read bank, one cycle later
//   rd_row    packet engine's current row (0..ROWS-1)
//   start     read bank holds a complete band
//   band_cnt  index of the band in the read bank
//   sof_drop  one-cycle pulse: a partial band was discarded by wr_sof
// -----------------------------------------------------------------------------
module dphy_band_buffer
   import dphy_pkg::*;
#(
   parameter int COLS      = DPHY_COLS,
   parameter int ROWS      = DPHY_ROWS,
   parameter int BAND_ROWS = DPHY_BAND_ROWS,
   parameter int DATA_W    = DPHY_DATA_W,
   parameter int ADDR_W    = DPHY_ADDR_W
)(
   input  logic              sysclk,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic              wr_sof,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic [7:0]        rd_row,
   output logic              start,
   output logic [4:0]        band_cnt,
   output logic              sof_drop
);

   localparam int BAND_SIZE = COLS * BAND_ROWS;
   localparam int BANDS     = ROWS / BAND_ROWS;

   // ---------------------------------------------------------------- state
   logic [0:0]  w_state_q,  w_state_d;
   logic        wr_bank_q,  wr_bank_d;
   logic [7:0]  wr_row_q,   wr_row_d;
   logic [7:0]  wr_col_q,   wr_col_d;
   logic [1:0]  full_q,     full_d;
   logic        rd_bank_q,  rd_bank_d;
   logic [7:0]  rd_row_q,   rd_row_d;
   logic [4:0]  band_cnt_q, band_cnt_d;
   logic        sof_drop_q, sof_drop_d;
   // Holds wr_ready low for the first cycle out of reset
   logic        ready_en_q, ready_en_d;

   // ---------------------------------------------------------------- helpers
   logic              wr_ready_int;
   logic              wr_fire;
   logic [7:0]        row_eff;
   logic [7:0]        col_eff;
   logic              col_last;
   logic              band_last;
   logic              band_partial;
   logic              set_full;
   logic              rd_release;
   logic [ADDR_W-1:0] wr_addr;

   // ------------------------------------------------------------ write side
   always_comb begin
      wr_ready_int = ready_en_q && (w_state_q == W_FILL) && !full_q[wr_bank_q];
      wr_fire      = wr_valid && wr_ready_int;

      // wr_sof restarts the band: the pixel it qualifies is written as (0,0)
      row_eff      = wr_sof ? 8'd0 : wr_row_q;
      col_eff      = wr_sof ? 8'd0 : wr_col_q;
      band_partial = (wr_row_q[2:0] != 3'd0) || (wr_col_q != 8'd0);

      col_last     = (col_eff == 8'(COLS - 1));
      band_last    = col_last && (row_eff[2:0] == 3'(BAND_ROWS - 1));
      wr_addr      = ADDR_W'(dphy_tile_addr(row_eff[2:0], col_eff));

      w_state_d    = w_state_q;
      wr_bank_d    = wr_bank_q;
      wr_row_d     = wr_row_q;
      wr_col_d     = wr_col_q;
      sof_drop_d   = 1'b0;
      ready_en_d   = 1'b1;
      set_full     = 1'b0;

      if (wr_fire) begin
         sof_drop_d = wr_sof && band_partial;
         if (col_last) begin
            wr_col_d = 8'd0;
            wr_row_d = (row_eff == 8'(ROWS - 1)) ? 8'd0 : row_eff + 8'd1;
         end else begin
            wr_col_d = col_eff + 8'd1;
            wr_row_d = row_eff;
         end
         if (band_last) begin
            set_full  = 1'b1;
            wr_bank_d = ~wr_bank_q;
            w_state_d = W_WAIT;
         end
      end else if ((w_state_q == W_WAIT) && !full_q[wr_bank_q]) begin
         // Registered hand-back: the freed bank is seen one cycle after
         // its flag clears, which guarantees a bubble between bands.
         w_state_d = W_FILL;
      end
   end

   // ------------------------------------------------------------- read side
   always_comb begin
      // Leaving the last row of a band releases it; a change while the read
      // bank is empty has nothing to release.
      rd_release = (rd_row_q[2:0] == 3'(BAND_ROWS - 1))
                && (rd_row != rd_row_q)
                && full_q[rd_bank_q];

      rd_row_d   = rd_row;
      rd_bank_d  = rd_bank_q;
      band_cnt_d = band_cnt_q;

      if (rd_release) begin
         rd_bank_d  = ~rd_bank_q;
         band_cnt_d = (band_cnt_q == 5'(BANDS - 1)) ? 5'd0 : band_cnt_q + 5'd1;
      end
   end

   // Per-bank full flags. Set and release never target the same bank (the
   // writer only fills an empty bank, release needs a full one), so both can
   // take effect in the same cycle.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_full
         assign full_d[gi] = (set_full   && (wr_bank_q == 1'(gi))) ? 1'b1 :
                             (rd_release && (rd_bank_q == 1'(gi))) ? 1'b0 :
                             full_q[gi];
      end
   endgenerate

   // ------------------------------------------------------------- registers
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         w_state_q  <= W_FILL;
         wr_bank_q  <= 1'b0;
         wr_row_q   <= 8'd0;
         wr_col_q   <= 8'd0;
         full_q     <= 2'b00;
         rd_bank_q  <= 1'b0;
         rd_row_q   <= 8'd0;
         band_cnt_q <= 5'd0;
         sof_drop_q <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         wr_bank_q  <= wr_bank_d;
         wr_row_q   <= wr_row_d;
         wr_col_q   <= wr_col_d;
         full_q     <= full_d;
         rd_bank_q  <= rd_bank_d;
         rd_row_q   <= rd_row_d;
         band_cnt_q <= band_cnt_d;
         sof_drop_q <= sof_drop_d;
         ready_en_q <= ready_en_d;
      end
   end

   // ------------------------------------------------------------- storage
   dphy_band_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (BAND_SIZE)
   ) u_ram (
      .clk     (sysclk),
      .rst     (reset),
      .wr_en   (wr_fire),
      .wr_bank (wr_bank_q),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_bank (rd_bank_q),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // ------------------------------------------------------------- outputs
   assign wr_ready = wr_ready_int;
   assign start    = full_q[rd_bank_q];
   assign band_cnt = band_cnt_q;
   assign sof_drop = sof_drop_q;

endmodule

// File: tb/tb_dphy_band_buffer.sv
// -----------------------------------------------------------------------------
// tb_dphy_band_buffer
// Self-checking bench for dphy_band_buffer. A reference model tracks the
// buffer at pixel/band level (pixel count inside the band, bank flags, a
// [bank][row][col] image) and every cycle is compared against it. Directed
// sequences add fixed expectations for the corner cases.
// -----------------------------------------------------------------------------
module tb_dphy_band_buffer;

   logic        sysclk = 1'b0;
   logic        reset = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic        wr_sof = 1'b0;
   logic [15:0] wr_data = '0;
   logic [11:0] rd_addr = '0;
   logic [15:0] rd_data;
   logic [7:0]  rd_row = '0;
   logic        start;
   logic [4:0]  band_cnt;
   logic        sof_drop;

   always #5 sysclk = ~sysclk;

   dphy_band_buffer dut (
      .sysclk   (sysclk),
      .reset    (reset),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_sof   (wr_sof),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_row   (rd_row),
      .start    (start),
      .band_cnt (band_cnt),
      .sof_drop (sof_drop)
   );

   int n_cmp = 0;
   int n_fail = 0;

   function automatic void chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // ------------------------------------------------------ reference model
   bit [15:0] m_pix   [2][8][240];
   bit        m_known [2][8][240];
   int        m_p;          // pixels already in the band being filled
   bit        m_wb, m_rb, m_wait, m_init, m_drop, m_rd_known, m_last_xfer;
   bit [1:0]  m_full;
   int        m_bc, m_rowq, m_rel_count, m_rd;
   int        drop_seen;

   function automatic void model_reset();
      m_full = 2'b00; m_wb = 0; m_rb = 0; m_wait = 0; m_init = 0;
      m_p = 0; m_bc = 0; m_rowq = 0; m_drop = 0; m_rd = 0; m_rd_known = 1;
      m_rel_count = 0; m_last_xfer = 0;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   function automatic void model_step();
      bit       ready, xfer;
      bit [1:0] full_pre;
      int       a, r, c;
      full_pre    = m_full;
      ready       = m_init && !m_wait && !full_pre[m_wb];
      xfer        = wr_valid && ready;
      m_last_xfer = xfer;
      // Tile address back to (row, col) inside the band
      a = int'(rd_addr);
      if (a < 1920) begin
         r = (a % 64) / 8;
         c = (a / 64) * 8 + a % 8;
         m_rd_known = m_known[m_rb][r][c];
         m_rd = int'(m_pix[m_rb][r][c]);
      end else begin
         m_rd_known = 0;
      end
      m_drop = 0;
      if (xfer) begin
         if (wr_sof) begin
            m_drop = (m_p != 0);
            m_p = 0;
         end
         m_pix[m_wb][m_p / 240][m_p % 240]   = wr_data;
         m_known[m_wb][m_p / 240][m_p % 240] = 1;
         if (m_p == 1919) begin
            m_full[m_wb] = 1; m_wb = !m_wb; m_wait = 1; m_p = 0;
         end else begin
            m_p++;
         end
      end else if (m_wait && !full_pre[m_wb]) begin
         m_wait = 0;
      end
      if ((m_rowq % 8) == 7 && int'(rd_row) != m_rowq && full_pre[m_rb]) begin
         m_full[m_rb] = 0; m_rb = !m_rb; m_bc = (m_bc + 1) % 30; m_rel_count++;
      end
      m_rowq = int'(rd_row);
      m_init = 1;
   endfunction

   function automatic void check_all();
      chk("wr_ready", int'(wr_ready), int'(m_init && !m_wait && !m_full[m_wb]));
      chk("start", int'(start), int'(m_full[m_rb]));
      chk("band_cnt", int'(band_cnt), m_bc);
      chk("sof_drop", int'(sof_drop), int'(m_drop));
      if (m_rd_known) chk("rd_data", int'(rd_data), m_rd);
      if (sof_drop === 1'b1) drop_seen++;
   endfunction

   task automatic cycle();
      model_step();
      @(posedge sysclk);
      #1;
      check_all();
   endtask

   task automatic do_reset(string tag);
      reset = 1'b1;
      model_reset();
      @(posedge sysclk);
      #1;
      chk({tag, "_ready"},    int'(wr_ready), 0);
      chk({tag, "_start"},    int'(start), 0);
      chk({tag, "_rd_data"},  int'(rd_data), 0);
      chk({tag, "_band_cnt"}, int'(band_cnt), 0);
      chk({tag, "_sof_drop"}, int'(sof_drop), 0);
      reset = 1'b0;
   endtask

   // Present one pixel and hold it until accepted; wr_valid stays high.
   task automatic write_pixel(input logic [15:0] d, input bit sof);
      bit done = 0;
      wr_valid = 1'b1;
      wr_sof   = sof;
      wr_data  = d;
      rd_addr  = 12'($urandom_range(0, 1919));
      for (int k = 0; k < 5000 && !done; k++) begin
         cycle();
         done = m_last_xfer;
      end
      if (!done) chk("write_timeout", 0, 1);
      wr_sof = 1'b0;
   endtask

   typedef struct {
      string name;
      int    addr;
      int    exp_data;
   } rd_vec_t;

   rd_vec_t tbl[9];
   int      start_bad;
   bit      first;
   bit      done_frame;

   initial begin
      // Band 0 holds linear index row*240+col; address -> expected pixel
      tbl[0] = '{"rd_a000", 12'h000, 0};
      tbl[1] = '{"rd_a007", 12'h007, 7};
      tbl[2] = '{"rd_a008", 12'h008, 240};
      tbl[3] = '{"rd_a048", 12'h048, 248};
      tbl[4] = '{"rd_a040", 12'h040, 8};
      tbl[5] = '{"rd_a03f", 12'h03F, 1687};
      tbl[6] = '{"rd_a77f", 12'h77F, 1919};
      tbl[7] = '{"rd_a740", 12'h740, 232};
      tbl[8] = '{"rd_a1a3", 12'h1A3, 1011};

      drop_seen = 0;
      do_reset("rst0");

      // ---- first band, data = linear index
      for (int i = 0; i < 1919; i++) write_pixel(16'(i), 0);
      chk("band1_start_before", int'(start), 0);
      write_pixel(16'd1919, 0);
      wr_valid = 1'b0;
      chk("band1_start_after", int'(start), 1);
      for (int i = 0; i < 9; i++) begin
         rd_addr = 12'(tbl[i].addr);
         cycle();
         chk(tbl[i].name, int'(rd_data), tbl[i].exp_data);
      end

      // ---- second band with rd_row held at 0: writer stalls
      for (int i = 0; i < 1920; i++) write_pixel(16'(1920 + i), 0);
      wr_valid = 1'b0;
      chk("stall_ready_0", int'(wr_ready), 0);
      repeat (4) cycle();
      chk("stall_ready_4", int'(wr_ready), 0);
      rd_row = 8'd7;
      cycle();
      rd_row = 8'd8;
      cycle();
      cycle();
      chk("release_ready", int'(wr_ready), 1);
      chk("release_bcnt", int'(band_cnt), 1);
      rd_addr = 12'h048;
      cycle();
      chk("bank1_a048", int'(rd_data), 1920 + 248);

      // ---- last write of a band together with release of the other bank
      rd_row = 8'd15;
      start_bad = 0;
      for (int i = 0; i < 1919; i++) begin
         write_pixel(16'(3840 + i), 0);
         if (start !== 1'b1) start_bad++;
      end
      rd_row = 8'd16;
      write_pixel(16'(3840 + 1919), 0);
      wr_valid = 1'b0;
      if (start !== 1'b1) start_bad++;
      cycle();
      if (start !== 1'b1) start_bad++;
      chk("simul_start_cont", start_bad, 0);
      chk("simul_bcnt", int'(band_cnt), 2);
      rd_row = 8'd23;
      cycle();
      rd_row = 8'd24;
      cycle();
      chk("empty_start", int'(start), 0);
      chk("empty_bcnt", int'(band_cnt), 3);

      // ---- wr_sof at pixel 500 of a band
      drop_seen = 0;
      start_bad = 0;
      for (int i = 0; i < 500; i++) write_pixel(16'($urandom), 0);
      write_pixel(16'hABCD, 1);
      for (int i = 0; i < 1918; i++) begin
         write_pixel(16'($urandom), 0);
         if (start !== 1'b0) start_bad++;
      end
      chk("sof_start_held", start_bad, 0);
      write_pixel(16'h1234, 0);
      wr_valid = 1'b0;
      chk("sof_start_after", int'(start), 1);
      rd_addr = 12'h000;
      cycle();
      chk("sof_pixel_at_0", int'(rd_data), 16'hABCD);
      cycle();
      chk("sof_drop_pulses", drop_seen, 1);

      // ---- reset while waiting for a bank, then mid-band
      for (int i = 0; i < 1920; i++) write_pixel(16'($urandom), 0);
      wr_valid = 1'b0;
      cycle();
      chk("wait_ready", int'(wr_ready), 0);
      chk("wait_start", int'(start), 1);
      do_reset("rst_wait");
      for (int i = 0; i < 100; i++) write_pixel(16'($urandom), 0);
      wr_valid = 1'b0;
      do_reset("rst_mid");
      repeat (3) cycle();
      chk("rst_mid_start_later", int'(start), 0);

      // ---- full frame, random data, consumer stepping rd_row 0..239
      rd_row = 8'd0;
      do_reset("rst_frame");
      first = 1;
      done_frame = 0;
      for (int k = 0; k < 70000 && !done_frame; k++) begin
         wr_valid = ($urandom_range(0, 31) != 0);
         wr_sof   = first;
         wr_data  = 16'($urandom);
         rd_addr  = 12'($urandom_range(0, 1919));
         if (m_full[m_rb] && $urandom_range(0, 7) == 0)
            rd_row = (rd_row == 8'd239) ? 8'd0 : rd_row + 8'd1;
         cycle();
         if (m_last_xfer) first = 0;
         done_frame = (m_rel_count >= 30);
      end
      wr_valid = 1'b0;
      wr_sof = 1'b0;
      if (!done_frame) chk("frame_timeout", 0, 1);
      chk("frame_bcnt_wrap", int'(band_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
